matmul_small_k_sequencer: RTL
=============================

// Module: matmul_small_k_sequencer
// PURPOSE
//  Sequencer for the small-K matmul MAC datapath (C = A*B, A: MxK, B: KxN, row-major).
//  Accepts one command. Issues the operand address stream to the MAC in i/j/k order, with i outermost and k innermost.
//  Marks the first and last k of each output. Collects MAC results in a credit-limited FIFO and writes C back in order.
// PARAMETERS
//  AW      16  address width; all address arithmetic is mod 2^AW
//  DW      32  accumulator / result data width
//  DIMW     8  width of M and N
//  KW       4  width of K (small-K: 1..2^KW-1)
//  MAX_OUT  4  max outputs whose op_last beat is issued but not yet written; this is also the FIFO depth
// PORTS
//  clk         in   1     clock
//  rst         in   1     synchronous active-high reset
//  cmd_valid   in   1     command valid
//  cmd_ready   out  1     high only in IDLE
//  cmd_m       in   DIMW  rows of A/C
//  cmd_n       in   DIMW  cols of B/C
//  cmd_k       in   KW    inner dimension
//  cmd_a_base  in   AW    base address of A
//  cmd_b_base  in   AW    base address of B
//  cmd_c_base  in   AW    base address of C
//  op_valid    out  1     operand beat valid
//  op_ready    in   1     MAC accepts beat
//  op_a_addr   out  AW    A[i][k] address
//  op_b_addr   out  AW    B[k][j] address
//  op_first    out  1     k==0: MAC clears accumulator
//  op_last     out  1     k==K-1: MAC emits result
//  acc_valid   in   1     MAC result valid; cannot be backpressured
//  acc_data    in   DW    MAC result
//  wr_valid    out  1     C write valid; equals FIFO non-empty
//  wr_ready    in   1     C write accepted
//  wr_addr     out  AW    C[i][j] address
//  wr_data     out  DW    FIFO head
//  busy        out  1     state != IDLE
//  done        out  1     1-cycle completion pulse
//  err         out  1     valid with done: zero dimension or FIFO overflow
// BEHAVIOUR
//  Reset: state=IDLE; FIFO flushed; all counters cleared.
//   op_valid, wr_valid, done, err and busy are 0. cmd_ready is 1 from the first cycle after rst falls.
//   Reset mid-operation aborts it; no done is produced.
//  FSM states:
//   IDLE : on cmd_valid, capture the command.
//          If any dimension is 0, go to DONE with err=1. Otherwise go to ISSUE.
//   ISSUE: op_valid = (outstanding < MAX_OUT). Counters advance on op_valid & op_ready.
//          After the handshake of the beat with i=M-1, j=N-1, k=K-1, go to DRAIN.
//   DRAIN: wait for outstanding==0, then go to DONE.
//   DONE : done=1 for exactly one cycle; err reported; go to IDLE. cmd_ready=0 in this state.
//  Addressing is incremental; no multipliers.
//   a_addr = a_base + i*K + k; A row base advances by K per row.
//   b_addr = b_base + k*N + j; advances by N per k, reloads to b_base+j at k==0.
//   wr_addr = c_base + (write count), incremented on each wr handshake.
//   All address arithmetic wraps mod 2^AW.
//  op_* outputs are registered and held stable while op_valid & !op_ready.
//  op_first = (k==0) and op_last = (k==K-1). With K=1 both are 1 on every beat.
//  outstanding: +1 on a handshake of a beat with op_last; -1 on a wr handshake.
//   Both in the same cycle: no change.
//  FIFO: push on acc_valid. Push and pop in the same cycle are allowed, including when the FIFO is full.
//   acc_valid while full and not popping: drop the data, set sticky err. The command still completes.
//  Results are written in issue order: i-major, then j.
//  cmd_valid outside IDLE is ignored.
// TESTING
//  T1 M=2,N=2,K=3, A=0x000, B=0x100, C=0x200, op_ready=1:
//     -> 12 beats. Beat1 (0x000,0x100,first). Beat2 b=0x102. Beat4 (0x000,0x101).
//     -> last on beats 3,6,9,12. acc 10,20,30,40 -> writes (0x200,10)..(0x203,40).
//     -> done=1, err=0 one cycle after the DRAIN exit.
//  T2 MAX_OUT=4, M=1,N=8,K=1, wr_ready=0, MAC returns each result 2 cycles after its beat:
//     -> exactly 4 beats, then op_valid=0.
//     -> wr_ready=1 -> remaining 4 beats issue; 8 writes in order.
//  T3 cmd_k=0 (also cmd_m=0):
//     -> accepted, zero op beats, done=1 with err=1 one cycle after accept, back in IDLE.
//  T4 T1 with op_ready toggling pseudo-randomly:
//     -> op_* stable while stalled; identical beat sequence to T1.
//  T5 a_base=0xFFFE, K=4, M=N=1 -> op_a_addr 0xFFFE,0xFFFF,0x0000,0x0001.
//     Extra acc_valid while full -> err=1 at done.
//  T6 rst=1 mid-ISSUE in T1:
//     -> next cycle op_valid=0, wr_valid=0, busy=0. No done.
//     -> a new command runs T1 correctly.

Source files
------------

// File: rtl/matmul_small_k_sequencer_if.sv
// Command, operand, result and write-back signals of the small-K matmul sequencer.
// master is the sequencer side; slave is the command source / MAC / memory side.
interface matmul_small_k_sequencer_if #(
    parameter int AW   = 16,
    parameter int DW   = 32,
    parameter int DIMW = 8,
    parameter int KW   = 4
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic [DIMW-1:0] cmd_m;
    logic [DIMW-1:0] cmd_n;
    logic [KW-1:0]   cmd_k;
    logic [AW-1:0]   cmd_a_base;
    logic [AW-1:0]   cmd_b_base;
    logic [AW-1:0]   cmd_c_base;
    logic            op_valid;
    logic            op_ready;
    logic [AW-1:0]   op_a_addr;
    logic [AW-1:0]   op_b_addr;
    logic            op_first;
    logic            op_last;
    logic            acc_valid;
    logic [DW-1:0]   acc_data;
    logic            wr_valid;
    logic            wr_ready;
    logic [AW-1:0]   wr_addr;
    logic [DW-1:0]   wr_data;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        input  cmd_valid, cmd_m, cmd_n, cmd_k, cmd_a_base, cmd_b_base, cmd_c_base,
        input  op_ready, acc_valid, acc_data, wr_ready,
        output cmd_ready, op_valid, op_a_addr, op_b_addr, op_first, op_last,
        output wr_valid, wr_addr, wr_data, busy, done, err
    );

    modport slave (
        output cmd_valid, cmd_m, cmd_n, cmd_k, cmd_a_base, cmd_b_base, cmd_c_base,
        output op_ready, acc_valid, acc_data, wr_ready,
        input  cmd_ready, op_valid, op_a_addr, op_b_addr, op_first, op_last,
        input  wr_valid, wr_addr, wr_data, busy, done, err
    );
endinterface

// File: rtl/matmul_small_k_sequencer.sv
// Walks i/j/k for C = A*B issuing MAC operand addresses, then writes the MAC results
// back to C in order through a credit-limited FIFO.
module matmul_small_k_sequencer #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int DIMW    = 8,
    parameter int KW      = 4,
    parameter int MAX_OUT = 4
) (
    input  logic clk,
    input  logic rst,
    matmul_small_k_sequencer_if.master bus
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;
    state_e state_q, state_d;

    logic [DIMW-1:0] m_q, n_q, i_q, j_q;
    logic [KW-1:0]   k_q, kc_q;
    logic [AW-1:0]   a_row_q, a_addr_q, b_base_q, b_col_q, b_addr_q, c_addr_q;
    logic [OW-1:0]   out_q, cnt_q;
    logic            err_q;
    logic [DW-1:0]   fifo_q [MAX_OUT];
    logic [PW-1:0]   wp_q, rp_q;

    logic          op_valid, op_fire, wr_fire, last_k, last_j, last_i, zero_dim;
    logic          full, push, ovf, out_inc, out_dec, accept;
    logic [AW-1:0] a_row_nx;

    assign last_k   = (kc_q == k_q - KW'(1));
    assign last_j   = (j_q == n_q - DIMW'(1));
    assign last_i   = (i_q == m_q - DIMW'(1));
    assign zero_dim = (bus.cmd_m == '0) | (bus.cmd_n == '0) | (bus.cmd_k == '0);
    assign accept   = (state_q == IDLE) & bus.cmd_valid;
    assign op_fire  = op_valid & bus.op_ready;
    assign wr_fire  = bus.wr_valid & bus.wr_ready;
    assign full     = (cnt_q == OW'(MAX_OUT));
    // A full FIFO can still take a result when its head leaves in the same cycle.
    assign push     = bus.acc_valid & (~full | wr_fire);
    assign ovf      = bus.acc_valid & full & ~wr_fire;
    assign out_inc  = op_fire & last_k;
    assign out_dec  = wr_fire & (out_q != '0);
    assign a_row_nx = a_row_q + AW'(k_q);

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.op_valid  = op_valid;
    assign bus.op_a_addr = a_addr_q;
    assign bus.op_b_addr = b_addr_q;
    assign bus.op_first  = (kc_q == '0);
    assign bus.op_last   = last_k;
    assign bus.wr_valid  = (cnt_q != '0);
    assign bus.wr_addr   = c_addr_q;
    assign bus.wr_data   = fifo_q[rp_q];
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.err       = (state_q == DONE) & err_q;

    always_comb begin
        state_d  = state_q;
        op_valid = 1'b0;
        unique case (state_q)
            IDLE:  if (bus.cmd_valid) state_d = zero_dim ? DONE : ISSUE;
            ISSUE: begin
                op_valid = (out_q < OW'(MAX_OUT));
                if (op_valid & bus.op_ready & last_k & last_j & last_i) state_d = DRAIN;
            end
            DRAIN: if (out_q == '0) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            {m_q, n_q, i_q, j_q}                  <= '0;
            {k_q, kc_q}                           <= '0;
            {a_row_q, a_addr_q, b_base_q}         <= '0;
            {b_col_q, b_addr_q, c_addr_q}         <= '0;
            {out_q, cnt_q, wp_q, rp_q}            <= '0;
            err_q                                 <= 1'b0;
        end else begin
            if (accept) begin
                m_q      <= bus.cmd_m;
                n_q      <= bus.cmd_n;
                k_q      <= bus.cmd_k;
                {i_q, j_q, kc_q} <= '0;
                a_row_q  <= bus.cmd_a_base;
                a_addr_q <= bus.cmd_a_base;
                b_base_q <= bus.cmd_b_base;
                b_col_q  <= bus.cmd_b_base;
                b_addr_q <= bus.cmd_b_base;
                c_addr_q <= bus.cmd_c_base;
                err_q    <= zero_dim;
            end else begin
                if (ovf)     err_q    <= 1'b1;
                if (wr_fire) c_addr_q <= c_addr_q + AW'(1);
                // Incremental walk: k steps A by 1 and B by N; j/i wraps reload row/column bases.
                if (op_fire) begin
                    if (!last_k) begin
                        kc_q     <= kc_q + KW'(1);
                        a_addr_q <= a_addr_q + AW'(1);
                        b_addr_q <= b_addr_q + AW'(n_q);
                    end else begin
                        kc_q <= '0;
                        if (!last_j) begin
                            j_q      <= j_q + DIMW'(1);
                            b_col_q  <= b_col_q + AW'(1);
                            b_addr_q <= b_col_q + AW'(1);
                            a_addr_q <= a_row_q;
                        end else begin
                            j_q      <= '0;
                            i_q      <= i_q + DIMW'(1);
                            b_col_q  <= b_base_q;
                            b_addr_q <= b_base_q;
                            a_row_q  <= a_row_nx;
                            a_addr_q <= a_row_nx;
                        end
                    end
                end
            end
            case ({out_inc, out_dec})
                2'b10:   out_q <= out_q + OW'(1);
                2'b01:   out_q <= out_q - OW'(1);
                default: ;
            endcase
            if (push)    wp_q <= (wp_q == PW'(MAX_OUT - 1)) ? '0 : wp_q + PW'(1);
            if (wr_fire) rp_q <= (rp_q == PW'(MAX_OUT - 1)) ? '0 : rp_q + PW'(1);
            cnt_q <= cnt_q + OW'(push) - OW'(wr_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_q[wp_q] <= bus.acc_data;
    end
endmodule
